// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and geometry for the cache fill controllers
// Purpose: fill FSM state encoding and the default block geometry
//          (16-byte blocks of 8 x 16-bit words).
// Ports:   none (package).
package cache_pkg;

   typedef enum logic {
      FILL_IDLE = 1'b0,
      FILL_BUSY = 1'b1
   } fill_state_e;

   localparam int BLOCK_WORDS = 8;
   localparam int OFFSET_W    = $clog2(BLOCK_WORDS);
   localparam int BYTE_OFF_W  = OFFSET_W + 1;

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - modulo-WORDS word counter with clear and terminal count
// Purpose: counts words issued or received during a block fill.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr_i      synchronous clear (wins over inc_i)
//   inc_i      advance by one, wrapping modulo WORDS
//   cnt_o      current count
//   tc_o       count is WORDS-1 (next increment wraps)
module fill_counter
   import cache_pkg::*;
#(
   parameter int WORDS = BLOCK_WORDS,
   parameter int CW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [CW-1:0] cnt_o,
   output logic          tc_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == CW'(WORDS - 1));

endmodule

// File: rtl/dcache_fill_fsm.sv
// rtl/dcache_fill_fsm.sv - cache-miss block fill controller
// Purpose: on a miss, stalls the pipeline, streams one block from main
//          memory, writes each word into the data array and finally the tag.
// Optional feature: DCACHE_CRITICAL_WORD_FIRST_EN starts the fill at the
//          missed word and wraps; undefined, fills always run from offset 0.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   miss_detected, miss_address    cache lookup miss and its byte address
//   memory_data_valid, memory_data word returned by main memory (in order)
//   fsm_busy                       pipeline stall request
//   mem_read_en, memory_address    read request to main memory
//   write_data_array, data_word_idx, fill_data   data array word write
//   write_tag_array                tag write / valid set, with the last word
module dcache_fill_fsm #(
   parameter int ADDR_W      = 16,
   parameter int BLOCK_WORDS = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           miss_detected,
   input  logic [ADDR_W-1:0]              miss_address,
   input  logic                           memory_data_valid,
   input  logic [15:0]                    memory_data,
   output logic                           fsm_busy,
   output logic                           mem_read_en,
   output logic [ADDR_W-1:0]              memory_address,
   output logic                           write_data_array,
   output logic [$clog2(BLOCK_WORDS)-1:0] data_word_idx,
   output logic [15:0]                    fill_data,
   output logic                           write_tag_array
);
   import cache_pkg::*;

   localparam int OFF_W  = $clog2(BLOCK_WORDS);
   localparam int BYTE_W = OFF_W + 1;
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << BYTE_W) - 1);

   fill_state_e       state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              issue_done_q, issue_done_d;
   logic              wr_q, wr_d;
   logic [15:0]       fill_q, fill_d;

   logic              start_fill;
   logic              issue_inc;
   logic              accept;
   logic [OFF_W-1:0]  start_w;
   logic [OFF_W-1:0]  issue_cnt, recv_cnt;
   logic              issue_tc, recv_tc;
   logic [OFF_W-1:0]  req_off;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
   logic [OFF_W-1:0]  start_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= '0;
      end else if (start_fill) begin
         start_q <= miss_address[OFF_W:1];
      end
   end

   assign start_w = start_q;
`else
   assign start_w = '0;
`endif

   assign base_d  = miss_address & ~OFF_MASK;
   assign req_off = start_w + issue_cnt;

   always_comb begin
      state_d          = state_q;
      start_fill       = 1'b0;
      issue_inc        = 1'b0;
      accept           = 1'b0;
      mem_read_en      = 1'b0;
      memory_address   = '0;
      write_tag_array  = 1'b0;
      fsm_busy         = miss_detected;
      case (state_q)
         FILL_IDLE: begin
            if (miss_detected) begin
               state_d    = FILL_BUSY;
               start_fill = 1'b1;
            end
         end
         FILL_BUSY: begin
            fsm_busy        = 1'b1;
            issue_inc       = !issue_done_q;
            mem_read_en     = issue_inc;
            // Offset field of base is zero, so OR-ing the word offset in is the add.
            memory_address  = issue_inc ? (base_q | ADDR_W'({req_off, 1'b0})) : '0;
            write_tag_array = wr_q && recv_tc;
            // A word arriving alongside the final write would be a ninth word.
            accept          = !write_tag_array;
            if (write_tag_array) begin
               state_d = FILL_IDLE;
            end
         end
         default: state_d = FILL_IDLE;
      endcase
   end

   assign issue_done_d = start_fill ? 1'b0 : (issue_done_q | (issue_inc & issue_tc));
   assign wr_d         = accept & memory_data_valid;
   assign fill_d       = (accept & memory_data_valid) ? memory_data : fill_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FILL_IDLE;
         base_q       <= '0;
         issue_done_q <= 1'b0;
         wr_q         <= 1'b0;
         fill_q       <= '0;
      end else begin
         state_q      <= state_d;
         base_q       <= start_fill ? base_d : base_q;
         issue_done_q <= issue_done_d;
         wr_q         <= wr_d;
         fill_q       <= fill_d;
      end
   end

   fill_counter #(.WORDS(BLOCK_WORDS), .CW(OFF_W)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (start_fill),
      .inc_i (issue_inc),
      .cnt_o (issue_cnt),
      .tc_o  (issue_tc)
   );

   fill_counter #(.WORDS(BLOCK_WORDS), .CW(OFF_W)) u_recv_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (start_fill),
      .inc_i (wr_q),
      .cnt_o (recv_cnt),
      .tc_o  (recv_tc)
   );

   assign write_data_array = wr_q;
   assign data_word_idx    = start_w + recv_cnt;
   assign fill_data        = fill_q;

endmodule

// File: tb/tb_dcache_fill_fsm.sv
// tb/tb_dcache_fill_fsm.sv - self-checking bench for dcache_fill_fsm
module tb_dcache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        fsm_busy;
   logic        mem_read_en;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  data_word_idx;
   logic [15:0] fill_data;
   logic        write_tag_array;

   always #5 clk = ~clk;

   dcache_fill_fsm #(.ADDR_W(16), .BLOCK_WORDS(8)) dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .mem_read_en       (mem_read_en),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .data_word_idx     (data_word_idx),
      .fill_data         (fill_data),
      .write_tag_array   (write_tag_array)
   );

   typedef struct {
      int          due;
      logic [15:0] addr;
   } ret_t;

   ret_t        sched[$];
   logic [15:0] exp_req[$];
   logic [18:0] exp_wr[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int mem_lat = 3;
   int nwr     = 0;
   int ntag    = 0;
   int first_wr, tag_cyc, busy_fall, e0;
   int extra_at = -1;
   bit stray    = 1'b0;
   int tag_base;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] mkdata(input logic [15:0] a);
      return (a * 16'd37) ^ 16'hC35A;
   endfunction

   function automatic int crit(input logic [15:0] a);
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
      return int'(a[3:1]);
`else
      return 0;
`endif
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  32'(fsm_busy), 0);
      check({tag, "_rd"},    32'(mem_read_en), 0);
      check({tag, "_addr"},  32'(memory_address), 0);
      check({tag, "_wr"},    32'(write_data_array), 0);
      check({tag, "_idx"},   32'(data_word_idx), 0);
      check({tag, "_data"},  32'(fill_data), 0);
      check({tag, "_tag"},   32'(write_tag_array), 0);
   endtask

   // Raise a miss for the upcoming edge and queue the request order it implies.
   task automatic start_fill(input logic [15:0] a);
      int st;
      st = crit(a);
      miss_detected = 1'b1;
      miss_address  = a;
      for (int i = 0; i < 8; i++) begin
         exp_req.push_back((a & 16'hFFF0) | 16'(2 * ((st + i) % 8)));
      end
      e0        = cyc;
      first_wr  = -1;
      busy_fall = -1;
      nwr       = 0;
   endtask

   // One clock cycle: observe outputs mid-cycle, act as main memory, advance.
   task automatic tick();
      ret_t r;
      logic [18:0] e;
      #1;
      if (mem_read_en) begin
         if (exp_req.size() == 0) check("req_unexpected", 1, 0);
         else check("req_addr", 32'(memory_address), 32'(exp_req.pop_front()));
         sched.push_back('{due: cyc + mem_lat, addr: memory_address});
      end
      if (write_data_array) begin
         nwr++;
         if (first_wr < 0) first_wr = cyc;
         if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
         else begin
            e = exp_wr.pop_front();
            check("wr_idx",  32'(data_word_idx), 32'(e[18:16]));
            check("wr_data", 32'(fill_data), 32'(e[15:0]));
         end
      end
      if (write_tag_array) begin
         ntag++;
         tag_cyc = cyc;
         check("tag_with_last_wr", 32'(write_data_array), 1);
         check("tag_wr_count", nwr, 8);
      end
      if (!fsm_busy && busy_fall < 0 && cyc > e0) busy_fall = cyc;
      memory_data_valid = 1'b0;
      memory_data       = 16'h0;
      if (sched.size() > 0 && sched[0].due == cyc) begin
         r = sched.pop_front();
         memory_data_valid = 1'b1;
         memory_data       = mkdata(r.addr);
         exp_wr.push_back({r.addr[3:1], mkdata(r.addr)});
      end else if (stray || extra_at == cyc) begin
         memory_data_valid = 1'b1;
         memory_data       = 16'hDEAD;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic wait_tag(input int budget);
      int t0;
      t0 = ntag;
      for (int i = 0; i < budget && ntag == t0; i++) tick();
      check("tag_seen", ntag - t0, 1);
   endtask

   task automatic end_checks(input int tag_off, input int wr_off);
      tick();
      check("fill_nwr", nwr, 8);
      check("req_left", exp_req.size(), 0);
      check("wr_left", exp_wr.size(), 0);
      check("tag_cycle", tag_cyc - e0, tag_off);
      check("first_wr_cycle", first_wr - e0, wr_off);
      check("busy_fall_cycle", busy_fall - e0, tag_off + 1);
   endtask

   initial begin
      rst               = 1'b1;
      miss_detected     = 1'b0;
      miss_address      = 16'h0;
      memory_data_valid = 1'b0;
      memory_data       = 16'h0;
      e0 = 0; first_wr = -1; tag_cyc = -1; busy_fall = -1;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Miss at 0x1234, 4-cycle memory
      mem_lat = 3;
      start_fill(16'h1234);
      #1;
      check("busy_miss_cycle", 32'(fsm_busy), 1);
      tick();
      miss_detected = 1'b0;
      wait_tag(40);
      end_checks(12, 5);

      // Miss at 0x1236: critical-word order when enabled
      start_fill(16'h1236);
      tick();
      miss_detected = 1'b0;
      wait_tag(40);
      end_checks(12, 5);

      // 1-cycle memory, plus a ninth valid in the tag-write cycle
      mem_lat = 1;
      start_fill(16'hABC8);
      extra_at = e0 + 10;
      tick();
      miss_detected = 1'b0;
      wait_tag(40);
      end_checks(10, 3);
      extra_at = -1;

      // Stray valids in IDLE
      stray = 1'b1;
      repeat (3) tick();
      stray = 1'b0;
      repeat (2) tick();
      check("idle_stray_nwr", nwr, 8);
      check("idle_busy", 32'(fsm_busy), 0);

      // Miss held through a fill: one tag, then refill without a dead cycle
      mem_lat  = 3;
      tag_base = ntag;
      start_fill(16'h4000);
      wait_tag(40);
      check("held_one_tag", ntag - tag_base, 1);
      check("held_tag_cycle", tag_cyc - e0, 12);
      check("held_nwr", nwr, 8);
      start_fill(16'h4000);
      tick();
      miss_detected = 1'b0;
      wait_tag(40);
      end_checks(12, 5);

      // Reset after three words returned
      tag_base = ntag;
      start_fill(16'h2468);
      tick();
      miss_detected = 1'b0;
      for (int i = 0; i < 30 && nwr < 3; i++) tick();
      check("pre_rst_nwr", nwr, 3);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("midfill_rst");
      sched.delete();
      exp_req.delete();
      exp_wr.delete();
      tick();
      rst = 1'b0;
      repeat (4) tick();
      check("rst_no_tag", ntag - tag_base, 0);
      check("rst_no_read", exp_req.size(), 0);
      start_fill(16'h2468);
      tick();
      miss_detected = 1'b0;
      wait_tag(40);
      end_checks(12, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_fill_fsm.md
# dcache_fill_fsm

Cache-miss fill controller for the Phase 3 pipelined CPU. It answers the load/store memory requests raised by the decode stage's memory-read and memory-write controls once the cache reports a miss. On a miss it stalls the pipeline, streams one 16-byte block (8 × 16-bit words) out of the multi-cycle main memory, writes each returned word into the cache data array, and then writes the tag. One instance serves the I-cache and one serves the D-cache.

## Interface
- `ADDR_W`, 16: byte-address width.
- `BLOCK_WORDS`, 8: words per block. Must be a power of two.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `miss_detected` input 1: cache lookup missed this cycle.
- `miss_address` input ADDR_W: byte address of the missing access.
- `memory_data_valid` input 1: main memory returns a word this cycle.
- `memory_data` input 16: word returned by main memory.
- `fsm_busy` output 1: pipeline stall request.
- `mem_read_en` output 1: read request to main memory this cycle.
- `memory_address` output ADDR_W: byte address of the current read request.
- `write_data_array` output 1: write `fill_data` into the data array at `data_word_idx`.
- `data_word_idx` output log2(BLOCK_WORDS): word offset inside the block being written.
- `fill_data` output 16: registered copy of `memory_data`, aligned with `write_data_array`.
- `write_tag_array` output 1: write the tag and set the valid bit for the block.

## Operation
- States are IDLE and FILL.
- IDLE to FILL: on a clock edge where `miss_detected`=1.
  - Latch `base` = `miss_address` with offset bits [3:0] cleared.
  - Latch `start` = `miss_address`[3:1] when the critical-word feature is on, otherwise 0.
  - Clear `issue_cnt` and `recv_cnt`.
- FILL, request side: while `issue_cnt` < BLOCK_WORDS, each cycle:
  - drive `mem_read_en`=1 and `memory_address` = `base` + 2·((`start`+`issue_cnt`) mod BLOCK_WORDS);
  - increment `issue_cnt`.
  - `mem_read_en`=0 afterwards.
- FILL, return side: memory returns words in request order.
  - Each `memory_data_valid` registers `memory_data` into `fill_data`.
  - The next cycle drives `write_data_array`=1 with `data_word_idx` = (`start`+`recv_cnt`) mod BLOCK_WORDS.
  - Then `recv_cnt` increments.
- FILL to IDLE: in the cycle the last word is written (`recv_cnt` = BLOCK_WORDS−1), `write_tag_array`=1 together with the final `write_data_array`. The next state is IDLE.
- `fsm_busy` = (state==FILL) | `miss_detected`. It is combinational, so the pipeline stalls in the miss cycle itself.
- `miss_detected` is ignored while in FILL. `memory_data_valid` is ignored in IDLE, and also once `recv_cnt` reaches BLOCK_WORDS.
- Reset mid-fill: return to IDLE immediately and clear all counters. No tag write occurs, so the block stays invalid.
- Offset arithmetic is done in log2(BLOCK_WORDS) bits and wraps naturally. The `base` add cannot carry out of the offset field.

## Timing
- All outputs are 0 on reset, including `memory_address`, `fill_data` and `data_word_idx`.
- Miss sampled at edge E0: read requests go out in cycles E0+1 … E0+8, back-to-back.
- Write latency is one cycle from `memory_data_valid` to `write_data_array`.
- With 4-cycle memory, the first data write occurs in cycle E0+5 and the tag write in cycle E0+12. `fsm_busy` falls in cycle E0+13.
- A new miss in the cycle after returning to IDLE is accepted with no dead cycle.

## Configuration
- `DCACHE_CRITICAL_WORD_FIRST_EN` defined: the fill starts at the missed word offset and wraps modulo BLOCK_WORDS.
- Macro undefined: the fill always runs from offset 0 up to BLOCK_WORDS−1, and `start` is hard-wired to 0.

## Structure
- Package `cache_pkg` holds:
  - the state enum (`FILL_IDLE`, `FILL_BUSY`);
  - `BLOCK_WORDS`, `OFFSET_W` = log2(BLOCK_WORDS), and the byte-offset width.
- Sub-module `fill_counter`: a modulo-BLOCK_WORDS counter with `clr`, `inc` and a terminal-count output. It is instantiated twice, once for `issue_cnt` and once for `recv_cnt`.

## Test plan
- Miss at 0x1234, macro off, 4-cycle memory: requests to 0x1230, 0x1232 … 0x123E in consecutive cycles → data writes at idx 0–7 → tag write in cycle E0+12 → `fsm_busy` low in E0+13.
- Miss at 0x1236, macro on: request order 0x1236, 0x1238 … 0x123E, 0x1230, 0x1232, 0x1234 → `data_word_idx` sequence 3,4,5,6,7,0,1,2.
- `memory_data_valid` pulsed in IDLE, and a 9th valid after the fill → no `write_data_array`, state stays IDLE.
- `miss_detected` held high throughout a fill → exactly one fill and one tag write. Second fill starts on the edge after return to IDLE.
- `rst` asserted after 3 words returned → all outputs 0 asynchronously, `write_tag_array` never asserted. Next miss restarts at the block's first word.
- Memory with 1-cycle latency (valid overlapping requests) → 8 writes, correct idx, tag write with the last word.
